// File: rtl/alu_mc.sv
// Multi-cycle ALU: one-hot single-cycle ops plus iterative signed/unsigned multiply and divide.
// All results are registered behind a valid/ready handshake on both sides.
module alu_mc #(
    parameter int  WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      op,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             out_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [SHW-1:0]     cnt_r;
    logic               rdy_r;
    logic [WIDTH-1:0]   hi_r, lo_r, opnd_r, a_r;
    logic               is_div_r, neg_lo_r, neg_hi_r, dz_r;
    logic [WIDTH-1:0]   out_r, out_hi_r;
    logic               out_err_r, out_valid_r;

    logic               accept_s, onehot_s, multi_s, sgn_s, a_neg_s, b_neg_s;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s, sc_res_s;
    logic [WIDTH:0]     mul_sum_s, div_shift_s;
    logic [WIDTH-1:0]   div_rem_s;
    logic               div_ge_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;
    logic               load_s, res_err_s;
    logic [WIDTH-1:0]   res_lo_s, res_hi_s;

    assign in_ready  = rdy_r && (state_r == ST_IDLE) && (!out_valid_r || out_ready);
    assign accept_s  = in_valid && in_ready;
    assign onehot_s  = (op != 16'h0000) && ((op & (op - 16'h0001)) == 16'h0000);
    assign multi_s   = onehot_s && (op[3:0] != 4'h0);
    assign sgn_s     = op[3] | op[1];
    assign a_neg_s   = sgn_s && in0[WIDTH-1];
    assign b_neg_s   = sgn_s && in1[WIDTH-1];
    assign mag_a_s   = a_neg_s ? -in0 : in0;
    assign mag_b_s   = b_neg_s ? -in1 : in1;

    // One shift-add or restoring-divide step; the low-W subtraction is exact whenever it is used.
    assign mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    assign div_shift_s = {hi_r, lo_r[WIDTH-1]};
    assign div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
    assign div_rem_s   = div_shift_s[WIDTH-1:0] - opnd_r;

    assign prod_s = neg_lo_r ? -{hi_r, lo_r} : {hi_r, lo_r};
    assign quo_s  = neg_lo_r ? -lo_r : lo_r;
    assign rem_s  = neg_hi_r ? -hi_r : hi_r;

    assign out       = out_r;
    assign out_hi    = out_hi_r;
    assign out_err   = out_err_r;
    assign out_valid = out_valid_r;

    // Single-cycle operation results; anything not one-hot falls to zero.
    always_comb begin
        sc_res_s = '0;
        case (op)
            16'h8000: sc_res_s = in0 + in1;
            16'h4000: sc_res_s = in0 - in1;
            16'h2000: sc_res_s = {{(WIDTH-1){1'b0}}, ($signed(in0) < $signed(in1))};
            16'h1000: sc_res_s = {{(WIDTH-1){1'b0}}, (in0 < in1)};
            16'h0800: sc_res_s = in0 & in1;
            16'h0400: sc_res_s = ~(in0 | in1);
            16'h0200: sc_res_s = in0 | in1;
            16'h0100: sc_res_s = in0 ^ in1;
            16'h0080: sc_res_s = in1 << in0[SHW-1:0];
            16'h0040: sc_res_s = in1 >> in0[SHW-1:0];
            16'h0020: sc_res_s = $signed(in1) >>> in0[SHW-1:0];
            16'h0010: sc_res_s = {in1[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default:  sc_res_s = '0;
        endcase
    end

    // Output register load selection: FIX results take priority since no request is accepted while busy.
    always_comb begin
        load_s    = 1'b0;
        res_lo_s  = '0;
        res_hi_s  = '0;
        res_err_s = 1'b0;
        if (state_r == ST_FIX) begin
            load_s = 1'b1;
            if (!is_div_r) begin
                res_hi_s = prod_s[2*WIDTH-1:WIDTH];
                res_lo_s = prod_s[WIDTH-1:0];
            end else if (dz_r) begin
                res_lo_s = '1;
                res_hi_s = a_r;
            end else begin
                res_lo_s = quo_s;
                res_hi_s = rem_s;
            end
        end else if (accept_s && !multi_s) begin
            load_s    = 1'b1;
            res_lo_s  = sc_res_s;
            res_err_s = !onehot_s;
        end else begin
            load_s = 1'b0;
        end
    end

    // Next-state logic for the iterative sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && multi_s) state_s = ST_ITER;
                else                     state_s = ST_IDLE;
            end
            ST_ITER: begin
                if (cnt_r == SHW'(WIDTH-1)) state_s = ST_FIX;
                else                        state_s = ST_ITER;
            end
            ST_FIX:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_r <= ST_IDLE;
        else         state_r <= state_s;
    end

    // Holds in_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rdy_r <= 1'b0;
        else         rdy_r <= 1'b1;
    end

    // Iterative datapath: load magnitudes on accept, then one bit per cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r    <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            opnd_r   <= '0;
            a_r      <= '0;
            is_div_r <= 1'b0;
            neg_lo_r <= 1'b0;
            neg_hi_r <= 1'b0;
            dz_r     <= 1'b0;
        end else if (state_r == ST_IDLE) begin
            if (accept_s && multi_s) begin
                cnt_r    <= '0;
                hi_r     <= '0;
                a_r      <= in0;
                is_div_r <= op[1] | op[0];
                neg_lo_r <= a_neg_s ^ b_neg_s;
                neg_hi_r <= a_neg_s;
                dz_r     <= (in1 == '0);
                if (op[1] | op[0]) begin
                    lo_r   <= mag_a_s;
                    opnd_r <= mag_b_s;
                end else begin
                    lo_r   <= mag_b_s;
                    opnd_r <= mag_a_s;
                end
            end
        end else if (state_r == ST_ITER) begin
            cnt_r <= cnt_r + SHW'(1);
            if (is_div_r) begin
                hi_r <= div_ge_s ? div_rem_s : div_shift_s[WIDTH-1:0];
                lo_r <= {lo_r[WIDTH-2:0], div_ge_s};
            end else begin
                hi_r <= mul_sum_s[WIDTH:1];
                lo_r <= {mul_sum_s[0], lo_r[WIDTH-1:1]};
            end
        end
    end

    // Output registers; a same-cycle load keeps out_valid high across a pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_r       <= '0;
            out_hi_r    <= '0;
            out_err_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            out_r       <= res_lo_s;
            out_hi_r    <= res_hi_s;
            out_err_r   <= res_err_s;
            out_valid_r <= 1'b1;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: expected results are queued on acceptance and checked on each pop.
module tb_alu_mc;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         resetn;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  op;
    logic [W-1:0] in0, in1;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res, res_hi;
    logic         res_err;

    exp_t exp_next;
    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .in0(in0), .in1(in1), .out_valid(out_valid), .out_ready(out_ready),
        .out(res), .out_hi(res_hi), .out_err(res_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] lo, input logic [W-1:0] hi, input logic err);
        exp_t e;
        e.lo = lo; e.hi = hi; e.err = err;
        return e;
    endfunction

    // Behavioural reference using native operators.
    function automatic exp_t model(input logic [15:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0]   sa, sb;
        logic signed [2*W-1:0] sa64, sb64, ps;
        logic [2*W-1:0]        pu;
        sa = a; sb = b; sa64 = sa; sb64 = sb;
        case (o)
            16'h8000: return mk(a + b, '0, 1'b0);
            16'h4000: return mk(a - b, '0, 1'b0);
            16'h2000: return mk((sa < sb) ? 32'd1 : 32'd0, '0, 1'b0);
            16'h1000: return mk((a < b) ? 32'd1 : 32'd0, '0, 1'b0);
            16'h0800: return mk(a & b, '0, 1'b0);
            16'h0400: return mk(~(a | b), '0, 1'b0);
            16'h0200: return mk(a | b, '0, 1'b0);
            16'h0100: return mk(a ^ b, '0, 1'b0);
            16'h0080: return mk(b << a[4:0], '0, 1'b0);
            16'h0040: return mk(b >> a[4:0], '0, 1'b0);
            16'h0020: return mk(sb >>> a[4:0], '0, 1'b0);
            16'h0010: return mk({b[15:0], 16'h0000}, '0, 1'b0);
            16'h0008: begin ps = sa64 * sb64; return mk(ps[W-1:0], ps[2*W-1:W], 1'b0); end
            16'h0004: begin pu = {32'd0, a} * {32'd0, b}; return mk(pu[W-1:0], pu[2*W-1:W], 1'b0); end
            16'h0002: begin
                if (b == 32'd0) return mk(32'hFFFF_FFFF, a, 1'b0);
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return mk(32'h8000_0000, 32'd0, 1'b0);
                return mk(sa / sb, sa % sb, 1'b0);
            end
            16'h0001: begin
                if (b == 32'd0) return mk(32'hFFFF_FFFF, a, 1'b0);
                return mk(a / b, a % b, 1'b0);
            end
            default: return mk('0, '0, 1'b1);
        endcase
    endfunction

    // One clock: sample handshakes away from the edge, pop/compare, push on accept, advance.
    task automatic cycle(output bit acc);
        exp_t e;
        #1;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            chk("unexpected_out", (q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("out", res, e.lo);
                chk("out_hi", res_hi, e.hi);
                chk("out_err", res_err, e.err);
            end
        end
        if (acc) q.push_back(exp_next);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input exp_t e, output int n);
        bit acc;
        op = o; in0 = a; in1 = b; in_valid = 1'b1; exp_next = e;
        acc = 1'b0; n = 0;
        while (!acc && n < 100) begin
            cycle(acc);
            n++;
        end
        chk("accept_timeout", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain(output int n);
        bit acc;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            cycle(acc);
            n++;
        end
        chk("drain_timeout", (q.size() == 0), 1);
    endtask

    initial begin
        bit acc;
        int n;
        resetn = 1'b0; in_valid = 1'b0; op = 16'h0000; in0 = '0; in1 = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", res, 0);
        chk("rst_out_hi", res_hi, 0);
        chk("rst_out_err", res_err, 0);
        chk("rst_in_ready", in_ready, 0);
        resetn = 1'b1;
        #1;
        chk("in_ready_pre_edge", in_ready, 0);
        @(posedge clk);
        #1;
        chk("in_ready_post_rst", in_ready, 1);

        // Back-to-back add then sub with out_ready held high.
        issue(16'h8000, 32'h1, 32'h1, mk(32'h2, 32'h0, 1'b0), n);
        issue(16'h4000, 32'h3, 32'h2, mk(32'h1, 32'h0, 1'b0), n);
        chk("b2b_accept_wait", n, 1);
        chk("b2b_add_popped", q.size(), 1);
        drain(n);
        chk("b2b_sub_latency", n, 1);

        issue(16'h2000, 32'hFFFF_FFFF, 32'h1, mk(32'h1, 32'h0, 1'b0), n); drain(n);
        issue(16'h1000, 32'hFFFF_FFFF, 32'h1, mk(32'h0, 32'h0, 1'b0), n); drain(n);
        issue(16'h0020, 32'h4, 32'h8000_0000, mk(32'hF800_0000, 32'h0, 1'b0), n); drain(n);
        issue(16'h0010, 32'h0, 32'hBFC0, mk(32'hBFC0_0000, 32'h0, 1'b0), n); drain(n);

        // Multiply; operand changes while busy must be ignored.
        issue(16'h0008, 32'hFFFF_FFFE, 32'h3, mk(32'hFFFF_FFFA, 32'hFFFF_FFFF, 1'b0), n);
        op = 16'h8000; in0 = 32'h1234_5678; in1 = 32'h0BAD_F00D;
        drain(n);
        chk("mul_latency", n, W + 2);
        issue(16'h0004, 32'hFFFF_FFFE, 32'h3, mk(32'hFFFF_FFFA, 32'h2, 1'b0), n); drain(n);

        // Divide, including divide by zero and signed overflow.
        issue(16'h0002, 32'hFFFF_FFF9, 32'h2, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0), n); drain(n);
        chk("div_latency", n, W + 2);
        issue(16'h0001, 32'h7, 32'h0, mk(32'hFFFF_FFFF, 32'h7, 1'b0), n); drain(n);
        chk("divz_latency", n, W + 2);
        issue(16'h0002, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h8000_0000, 32'h0, 1'b0), n); drain(n);

        // Output stall: result holds, nothing accepted, then pop and accept together.
        out_ready = 1'b0;
        issue(16'h8000, 32'h5, 32'h6, mk(32'hB, 32'h0, 1'b0), n);
        op = 16'h0100; in0 = 32'hFF; in1 = 32'h0F; in_valid = 1'b1; exp_next = mk(32'hF0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(acc);
            chk("stall_accept", acc, 0);
            chk("stall_valid", out_valid, 1);
            chk("stall_out", res, 32'hB);
            chk("stall_in_ready", in_ready, 0);
        end
        op = 16'h8000; in0 = 32'h7; in1 = 32'h8; exp_next = mk(32'hF, 32'h0, 1'b0);
        out_ready = 1'b1;
        cycle(acc);
        chk("pop_accept", acc, 1);
        in_valid = 1'b0;
        drain(n);
        chk("pop_next_latency", n, 1);

        // Invalid opcodes.
        issue(16'h0000, 32'h1, 32'h2, mk(32'h0, 32'h0, 1'b1), n); drain(n);
        chk("err_latency", n, 1);
        issue(16'h8001, 32'h1, 32'h2, mk(32'h0, 32'h0, 1'b1), n); drain(n);

        // Mixed ops against the reference model.
        for (int i = 0; i < 32; i++) begin
            logic [15:0]  o;
            logic [W-1:0] a, b;
            o = 16'h8000 >> (i % 16);
            a = $urandom;
            b = $urandom;
            if (o[1] || o[0]) b = (i >= 16) ? 32'd0 : $urandom_range(1, 40);
            issue(o, a, b, model(o, a, b), n);
            drain(n);
        end

        // Reset in the middle of a divide.
        issue(16'h0001, 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0), n);
        for (int i = 0; i < 10; i++) cycle(acc);
        resetn = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out", res, 0);
        chk("midrst_in_ready", in_ready, 0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_in_ready_after", in_ready, 1);
        issue(16'h0001, 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0), n);
        drain(n);
        chk("midrst_divu_latency", n, W + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU with a valid/ready handshake on its input and output. It keeps the one-hot 12-operation single-cycle ALU set and adds iterative signed and unsigned multiply and divide. Every result is registered. It sits between the execute-stage issue logic and writeback. Single-cycle operations complete in 1 cycle; multiply and divide take WIDTH+1 cycles.

## Interface
- WIDTH, 32, datapath width; even, ≥ 8
- SHW, $clog2(WIDTH), shift-amount width (derived, do not override)
- clk  input  1  clock, rising edge
- resetn  input  1  reset, asynchronous, active-low
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request this cycle
- op  input  16  one-hot opcode, assigned as follows:
  - 15 add, 14 sub, 13 slt, 12 sltu
  - 11 and, 10 nor, 9 or, 8 xor
  - 7 sll, 6 srl, 5 sra, 4 lui
  - 3 mul (signed), 2 mulu, 1 div (signed), 0 divu
- in0  input  WIDTH  operand A; shift amount for shifts (in0[SHW-1:0])
- in1  input  WIDTH  operand B; value shifted for shifts; source for lui
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out  output  WIDTH  result; low product; quotient
- out_hi  output  WIDTH  high product; remainder; 0 for single-cycle ops
- out_err  output  1  op was not one-hot

## Operation
- Request accepted on a rising edge when in_valid && in_ready; op, in0 and in1 are captured then.
- in_ready = !busy && (!out_valid || out_ready). A new request may be accepted in the same cycle the current result is popped.
- Single-cycle ops:
  - add/sub: wrap modulo 2^WIDTH.
  - slt: signed in0<in1 → 1, else 0. sltu: the same comparison, unsigned.
  - Logic ops are bitwise. nor = ~(in0|in1).
  - sll/srl/sra shift in1 by in0[SHW-1:0]; sra sign-fills.
  - lui = {in1[WIDTH/2-1:0], WIDTH/2 zeros}.
- Multiply:
  - Iterative shift-add on operand magnitudes, 1 bit per cycle for WIDTH cycles.
  - Final cycle applies sign correction when mul is signed and the operand signs differ.
  - {out_hi,out} = full 2·WIDTH-bit product.
- Divide:
  - Restoring division on magnitudes, 1 quotient bit per cycle for WIDTH cycles.
  - Final cycle applies sign fix: quotient negative iff the operand signs differ; remainder takes the sign of in0.
  - out = quotient, out_hi = remainder.
- Divide by zero: out = all ones, out_hi = in0. Still takes the full WIDTH+1 latency; out_err = 0.
- Signed overflow (div, in0 = most-negative value, in1 = −1): out = most-negative value, out_hi = 0.
- Invalid op (zero or multi-hot): out = 0, out_hi = 0, out_err = 1. Single-cycle latency.
- State machine:
  - IDLE: on accepting a multi-cycle op → ITER, counter = 0, busy = 1. On accepting a single-cycle op, load the output register and stay in IDLE.
  - ITER: counter increments each cycle; when counter = WIDTH−1 → FIX.
  - FIX: load the output register, set out_valid, busy = 0, → IDLE.
- out_valid clears on out_valid && out_ready unless a new single-cycle result loads in the same cycle.
- Output registers (out, out_hi, out_err) hold their value until the next load, including while out_valid = 0.

## Timing
- Reset (resetn low, takes effect asynchronously):
  - out_valid = 0, out = 0, out_hi = 0, out_err = 0.
  - busy = 0, state = IDLE, counter = 0.
  - in_ready = 1 one cycle after resetn rises; 0 while resetn is low.
- Reset mid-operation aborts it; no result is produced.
- Single-cycle op accepted at edge k → out_valid high after edge k+1... specifically, the result is visible after edge k, with out_valid = 1 in cycle k+1.
- Multi-cycle op accepted at edge k:
  - ITER covers edges k+1 … k+WIDTH.
  - FIX loads on edge k+WIDTH+1.
  - out_valid is visible after edge k+WIDTH+1.
  - in_ready = 0 from after edge k until the result is popped, or until the edge on which out_ready is high during out_valid.
- Back-to-back single-cycle ops with out_ready tied high give 1 result per cycle.
- Output stall (out_ready = 0): result and out_valid hold; in_ready = 0; no input is accepted.
- Changes to in0/in1/op while busy are ignored.

## Test plan
- add in0=0x1, in1=0x1; then sub in0=0x3, in1=0x2, out_ready=1 throughout → out=0x2, then 0x1, on consecutive cycles; out_hi=0.
- slt in0=0xFFFFFFFF, in1=0x1 → out=1. sltu with the same operands → out=0. sra in1=0x80000000, in0=4 → out=0xF8000000. lui in1=0xBFC0 → out=0xBFC00000.
- mul in0=0xFFFFFFFE (−2), in1=0x3 → after 33 cycles out=0xFFFFFFFA, out_hi=0xFFFFFFFF. mulu with the same operands → out_hi=0x2, out=0xFFFFFFFA.
- div in0=−7 (0xFFFFFFF9), in1=2 → out=0xFFFFFFFD, out_hi=0xFFFFFFFF. divu 7/0 → out=0xFFFFFFFF, out_hi=0x7. div 0x80000000/0xFFFFFFFF → out=0x80000000, out_hi=0.
- Hold out_ready=0 for 5 cycles after a result:
  - Result is stable and in_ready=0 throughout.
  - On the pop cycle, a new add is accepted and its result appears on the next cycle.
  - op=0x0000 or 0x8001 → out_err=1, out=0.
- Assert resetn low at cycle 10 of a divu → out_valid=0 immediately. After release, in_ready=1 and a fresh op completes normally.
